// File: rtl/neuron_eval_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// neuron_eval_sequencer_pkg
//   Shared definitions for the 20-input perceptron evaluation slice:
//   datapath dimensions, the sequencer FSM state type, register-decoder
//   address constants and a sign-extension helper used by the datapath.
// -----------------------------------------------------------------------------
package neuron_eval_sequencer_pkg;

  // Datapath dimensions.
  localparam int N_COEF = 20;  // training coefficients / input bits
  localparam int COEF_W = 16;  // signed width of a coefficient and of the offset
  localparam int ACC_W  = 21;  // COEF_W + clog2(N_COEF+1): the full sum cannot overflow
  localparam int IDX_W  = 5;   // coefficient index width, >= clog2(N_COEF)

  // Register-decoder address map (word addresses on the host bus).
  localparam logic [7:0] ADDR_START     = 8'h00;  // write here raises Start
  localparam logic [7:0] ADDR_OFFSET    = 8'h01;  // offset coefficient
  localparam logic [7:0] ADDR_ENTRADA   = 8'h02;  // input vector
  localparam logic [7:0] ADDR_STATUS    = 8'h03;  // Busy/Valid/Result/Overrun
  localparam logic [7:0] ADDR_SUM       = 8'h04;  // accumulated sum
  localparam logic [7:0] ADDR_COEF_BASE = 8'h10;  // w[0] .. w[N_COEF-1]

  // Sequencer states: one LOAD cycle, N_COEF ACC cycles, one FIN cycle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ACC  = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  // Sign-extend a coefficient-width value to accumulator width.
  function automatic logic [ACC_W-1:0] sext_coef(input logic [COEF_W-1:0] v);
    return {{(ACC_W-COEF_W){v[COEF_W-1]}}, v};
  endfunction

endpackage : neuron_eval_sequencer_pkg

// File: rtl/neuron_eval_sequencer_if.sv
// -----------------------------------------------------------------------------
// neuron_eval_sequencer_if
//   Bundles the register-bank side of the sequencer.
//   master : register decoder / coefficient bank (drives requests, data, CoefIn)
//   slave  : neuron_eval_sequencer (drives index, status and result)
//   Start    start request level from the decoder
//   Write    bus write strobe; a start counts only with Start & Write
//   Entrada  input vector, bit i is x[i]
//   Offset   signed offset coefficient
//   CoefIn   coefficient selected by CoefSel (combinational mux)
//   CoefSel  coefficient index presented to the mux
//   Busy     evaluation in progress (register bank blocks writes)
//   Done     one-cycle pulse when Sum/Result update
//   Valid    Sum/Result hold a completed evaluation
//   Sum      signed accumulated sum
//   Result   neuron output, 1 when Sum >= 0
//   Overrun  sticky: a start arrived while busy
// -----------------------------------------------------------------------------
interface neuron_eval_sequencer_if;
  import neuron_eval_sequencer_pkg::*;

  logic              Start;
  logic              Write;
  logic [N_COEF-1:0] Entrada;
  logic [COEF_W-1:0] Offset;
  logic [COEF_W-1:0] CoefIn;
  logic [IDX_W-1:0]  CoefSel;
  logic              Busy;
  logic              Done;
  logic              Valid;
  logic [ACC_W-1:0]  Sum;
  logic              Result;
  logic              Overrun;

  modport master (
    output Start, Write, Entrada, Offset, CoefIn,
    input  CoefSel, Busy, Done, Valid, Sum, Result, Overrun
  );

  modport slave (
    input  Start, Write, Entrada, Offset, CoefIn,
    output CoefSel, Busy, Done, Valid, Sum, Result, Overrun
  );

endinterface : neuron_eval_sequencer_if

// File: rtl/neuron_eval_sequencer_mac_acc.sv
// -----------------------------------------------------------------------------
// neuron_mac_acc
//   Registered signed accumulator for the perceptron dot product.
//   load_i has priority and seeds the accumulator with the sign-extended
//   offset; add_i adds one sign-extended coefficient. The next-state value
//   is exposed so the sequencer can publish the final sum in the same cycle
//   the last product lands.
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   load_i      seed accumulator with load_val_i
//   load_val_i  signed offset (COEF_W)
//   add_i       add addend_i this cycle
//   addend_i    signed coefficient (COEF_W)
//   acc_next_o  value the accumulator takes at the next edge (ACC_W)
// -----------------------------------------------------------------------------
module neuron_mac_acc
  import neuron_eval_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [COEF_W-1:0] load_val_i,
  input  logic              add_i,
  input  logic [COEF_W-1:0] addend_i,
  output logic [ACC_W-1:0]  acc_next_o
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;

  // NOTE: every always_comb output gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = sext_coef(load_val_i);
    end else if (add_i) begin
      // Two's complement wraps, but ACC_W is wide enough that it never does.
      acc_d = acc_q + sext_coef(addend_i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_next_o = acc_d;

endmodule : neuron_mac_acc

// File: rtl/neuron_eval_sequencer.sv
// -----------------------------------------------------------------------------
// neuron_eval_sequencer
//   Runs one evaluation of the N_COEF-input perceptron per accepted start:
//   LOAD seeds the accumulator with Offset and snapshots Entrada, ACC walks
//   CoefSel 0..N_COEF-1 adding w[i] where x[i]=1, FIN publishes the result.
//   A trigger is the rising edge of Start & Write; a trigger seen while busy
//   (including the FIN cycle) is dropped and raises the sticky Overrun flag.
//   Ports
//     Clock    system clock, rising edge
//     Reset_n  asynchronous active-low reset
//     bus      neuron_eval_sequencer_if.slave (see interface header)
// -----------------------------------------------------------------------------
module neuron_eval_sequencer
  import neuron_eval_sequencer_pkg::*;
(
  input  logic                    Clock,
  input  logic                    Reset_n,
  neuron_eval_sequencer_if.slave  bus
);

  state_e            state_q, state_d;
  logic              start_q, start_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [N_COEF-1:0] xs_q, xs_d;
  logic [ACC_W-1:0]  sum_q, sum_d;
  logic              result_q, result_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;

  logic              trigger;
  logic              last_idx;
  logic              acc_load;
  logic              acc_add;
  logic [ACC_W-1:0]  acc_next;

  // Rising edge of the qualified start; a held Start & Write fires once.
  assign start_d  = bus.Start & bus.Write;
  assign trigger  = start_d & ~start_q;
  assign last_idx = (idx_q == IDX_W'(N_COEF - 1));

  neuron_mac_acc u_mac (
    .clk        (Clock),
    .rst_n      (Reset_n),
    .load_i     (acc_load),
    .load_val_i (bus.Offset),
    .add_i      (acc_add),
    .addend_i   (bus.CoefIn),
    .acc_next_o (acc_next)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    xs_d      = xs_q;
    sum_d     = sum_q;
    result_d  = result_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    acc_load  = 1'b0;
    acc_add   = 1'b0;

    // Accepted only from IDLE; anything else is an overrun and is dropped.
    if (trigger) begin
      if (state_q == ST_IDLE) begin
        overrun_d = 1'b0;
        valid_d   = 1'b0;
      end else begin
        overrun_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        acc_load = 1'b1;
        xs_d     = bus.Entrada;
        idx_d    = '0;
        state_d  = ST_ACC;
      end

      ST_ACC: begin
        // CoefIn is the mux output for idx_q in this same cycle.
        acc_add = xs_q[idx_q];
        if (last_idx) begin
          // Capture the completed sum as it enters the accumulator so that
          // Sum/Result/Valid are already valid while Done is high in FIN.
          idx_d    = '0;
          sum_d    = acc_next;
          result_d = ~acc_next[ACC_W-1];
          valid_d  = 1'b1;
          state_d  = ST_FIN;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: the Entrada snapshot is reset along with the control state; it is
  // only N_COEF flops, and a defined value keeps acc_add free of X after reset.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      start_q   <= 1'b0;
      idx_q     <= '0;
      xs_q      <= '0;
      sum_q     <= '0;
      result_q  <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      idx_q     <= idx_d;
      xs_q      <= xs_d;
      sum_q     <= sum_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  // Status decodes straight from the state register: Busy spans LOAD..FIN,
  // Done is exactly the single FIN cycle.
  assign bus.CoefSel = idx_q;
  assign bus.Busy    = (state_q != ST_IDLE);
  assign bus.Done    = (state_q == ST_FIN);
  assign bus.Valid   = valid_q;
  assign bus.Sum     = sum_q;
  assign bus.Result  = result_q;
  assign bus.Overrun = overrun_q;

endmodule : neuron_eval_sequencer

// File: tb/tb_neuron_eval_sequencer.sv
// -----------------------------------------------------------------------------
// tb_neuron_eval_sequencer
//   Directed stimulus against neuron_eval_sequencer. A cycle-level reference
//   model derives expected outputs from the trigger rule, the fixed latency
//   and a plain dot product; a compare process checks every cycle, and
//   directed checks pin the model to hand-computed sums.
// -----------------------------------------------------------------------------
module tb_neuron_eval_sequencer;
  import neuron_eval_sequencer_pkg::*;

  localparam int LAT = N_COEF + 2;  // trigger edge to Done cycle

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  neuron_eval_sequencer_if bus ();

  neuron_eval_sequencer dut (
    .Clock   (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  // Coefficient bank; the read mux is combinational on CoefSel.
  logic signed [COEF_W-1:0] coef_mem [0:31];
  assign bus.CoefIn = coef_mem[bus.CoefSel];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic signed [63:0] ref_sum(input logic [N_COEF-1:0] x,
                                                 input logic [COEF_W-1:0] off);
    logic signed [63:0] s;
    s = 64'($signed(off));
    for (int i = 0; i < N_COEF; i++) begin
      if (x[i]) s += 64'(coef_mem[i]);
    end
    return s;
  endfunction

  logic               m_sw_prev = 1'b0;
  logic               m_trig    = 1'b0;
  logic               m_busy    = 1'b0;
  int                 m_age     = 0;     // 0 idle, else cycles since accept
  logic               m_valid   = 1'b0;
  logic               m_overrun = 1'b0;
  logic               m_result  = 1'b0;
  logic signed [63:0] m_sum     = '0;
  logic signed [63:0] m_pending = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sw_prev = 1'b0;
      m_age     = 0;
      m_valid   = 1'b0;
      m_overrun = 1'b0;
      m_result  = 1'b0;
      m_sum     = '0;
    end else begin
      m_trig    = bus.Start & bus.Write & ~m_sw_prev;
      m_sw_prev = bus.Start & bus.Write;
      m_busy    = (m_age != 0);
      if (m_age == 1) m_pending = ref_sum(bus.Entrada, bus.Offset);
      if (m_age == LAT - 1) begin
        m_sum    = m_pending;
        m_result = (m_pending >= 0);
        m_valid  = 1'b1;
      end
      if (m_busy) m_age = (m_age == LAT) ? 0 : m_age + 1;
      if (m_trig && m_busy) m_overrun = 1'b1;
      if (m_trig && !m_busy) begin
        m_age     = 1;
        m_overrun = 1'b0;
        m_valid   = 1'b0;
      end
    end
  end

  // Per-cycle comparison, sampled away from the rising edge.
  always begin
    @(negedge clk);
    #1;
    check("busy",     64'(bus.Busy),    64'(m_age != 0));
    check("done",     64'(bus.Done),    64'(m_age == LAT));
    check("coef_sel", 64'(bus.CoefSel), 64'((m_age >= 2 && m_age <= LAT - 1) ? m_age - 2 : 0));
    check("valid",    64'(bus.Valid),   64'(m_valid));
    check("overrun",  64'(bus.Overrun), 64'(m_overrun));
    check("result",   64'(bus.Result),  64'(m_result));
    check("sum",      64'(bus.Sum),     64'(m_sum[ACC_W-1:0]));
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic set_coef_ramp();
    for (int i = 0; i < 32; i++) coef_mem[i] = COEF_W'(i + 1);
  endtask

  task automatic set_coef_const(input logic [COEF_W-1:0] v);
    for (int i = 0; i < 32; i++) coef_mem[i] = v;
  endtask

  // One-cycle Start & Write pulse; returns at negedge+1 of the cycle after the trigger edge.
  task automatic start_pulse();
    bus.Start = 1'b1;
    bus.Write = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    bus.Write = 1'b0;
    #1;
  endtask

  task automatic wait_sel(input int idx, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (bus.CoefSel != IDX_W'(idx) && n < 40);
    check(name, 64'(bus.CoefSel), 64'(idx));
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!bus.Done && n < 40);
    check(name, 64'(bus.Done), 64'(1));
  endtask

  // Pulse a start and count cycles until Done; optionally disturb Entrada and
  // Offset well after LOAD to show the snapshot is used.
  task automatic pulse_and_measure(output int lat, input logic disturb);
    bus.Start = 1'b1;
    bus.Write = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        bus.Start = 1'b0;
        bus.Write = 1'b0;
      end
      if (disturb && lat == 5) begin
        bus.Entrada = ~bus.Entrada;
        bus.Offset  = 16'h1234;
      end
      #1;
    end while (!bus.Done && lat < 100);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int lat;
    int ndone;

    bus.Start   = 1'b0;
    bus.Write   = 1'b0;
    bus.Entrada = '0;
    bus.Offset  = '0;
    set_coef_const('0);

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy",     64'(bus.Busy),    64'(0));
    check("rst_done",     64'(bus.Done),    64'(0));
    check("rst_valid",    64'(bus.Valid),   64'(0));
    check("rst_sum",      64'(bus.Sum),     64'(0));
    check("rst_result",   64'(bus.Result),  64'(0));
    check("rst_overrun",  64'(bus.Overrun), 64'(0));
    check("rst_coef_sel", 64'(bus.CoefSel), 64'(0));
    #1 rst_n = 1'b1;

    // Test 1: reset in the middle of ACC at index 7.
    set_coef_ramp();
    bus.Entrada = 20'hFFFFF;
    bus.Offset  = 16'hFFFB;
    @(negedge clk);
    #2;
    start_pulse();
    wait_sel(7, "t1_reach_idx7");
    #2 rst_n = 1'b0;
    #1;
    check("t1_busy",     64'(bus.Busy),    64'(0));
    check("t1_done",     64'(bus.Done),    64'(0));
    check("t1_coef_sel", 64'(bus.CoefSel), 64'(0));
    check("t1_valid",    64'(bus.Valid),   64'(0));
    check("t1_sum",      64'(bus.Sum),     64'(0));
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #2;

    // Test 2: Offset=-5, w[i]=i+1, all inputs -> 210-5 = 205, 22-cycle latency.
    pulse_and_measure(lat, 1'b0);
    check("t2_latency", 64'(lat),        64'(LAT));
    check("t2_sum",     64'(bus.Sum),    64'(205));
    check("t2_result",  64'(bus.Result), 64'(1));
    check("t2_valid",   64'(bus.Valid),  64'(1));
    check("t2_model",   64'(m_sum),      64'(205));
    @(negedge clk);
    #1;
    check("t2_done_pulse", 64'(bus.Done),  64'(0));
    check("t2_hold_sum",   64'(bus.Sum),   64'(205));
    check("t2_hold_valid", 64'(bus.Valid), 64'(1));

    // Test 3: Offset=-100, w=4, x=0xF -> -84; inputs changed after LOAD.
    set_coef_const(16'd4);
    bus.Entrada = 20'h0000F;
    bus.Offset  = 16'hFF9C;
    pulse_and_measure(lat, 1'b1);
    check("t3_latency", 64'(lat),        64'(LAT));
    check("t3_sum",     64'(bus.Sum),    64'(21'h1FFFAC));
    check("t3_result",  64'(bus.Result), 64'(0));
    check("t3_valid",   64'(bus.Valid),  64'(1));
    check("t3_model",   64'(m_sum),      64'(-84));

    // Test 4: Start & Write held 40 cycles -> one evaluation, no overrun.
    // Odd bits set, w[i]=i+1: 2+4+...+20 = 110, plus 7.
    set_coef_ramp();
    bus.Entrada = 20'hAAAAA;
    bus.Offset  = 16'd7;
    @(negedge clk);
    #2;
    bus.Start = 1'b1;
    bus.Write = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (bus.Done) ndone++;
    end
    bus.Start = 1'b0;
    bus.Write = 1'b0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (bus.Done) ndone++;
    end
    check("t4_done_count", 64'(ndone),       64'(1));
    check("t4_overrun",    64'(bus.Overrun), 64'(0));
    check("t4_busy",       64'(bus.Busy),    64'(0));
    check("t4_sum",        64'(bus.Sum),     64'(117));

    // Test 5: second start at ACC index 10 is dropped and sets Overrun.
    // Bits 4..7 and 12..15 with w[i]=i+1: 26 + 58 = 84.
    bus.Entrada = 20'h0F0F0;
    bus.Offset  = 16'd0;
    start_pulse();
    wait_sel(10, "t5_reach_idx10");
    start_pulse();
    check("t5_overrun_set", 64'(bus.Overrun), 64'(1));
    check("t5_still_busy",  64'(bus.Busy),    64'(1));
    wait_done("t5_done");
    check("t5_sum",         64'(bus.Sum),     64'(84));
    check("t5_overrun_hold",64'(bus.Overrun), 64'(1));
    @(negedge clk);
    #2;
    pulse_and_measure(lat, 1'b0);
    check("t5_overrun_clr", 64'(bus.Overrun), 64'(0));
    check("t5_latency",     64'(lat),         64'(LAT));
    // Trigger landing in the FIN cycle counts as busy.
    start_pulse();
    check("t5_fin_overrun", 64'(bus.Overrun), 64'(1));
    check("t5_fin_ignored", 64'(bus.Busy),    64'(0));
    repeat (2) @(negedge clk);
    #2;

    // Test 6: extreme coefficients, full input vector, no overflow.
    set_coef_const(16'h7FFF);
    bus.Entrada = 20'hFFFFF;
    bus.Offset  = 16'h7FFF;
    pulse_and_measure(lat, 1'b0);
    check("t6_sum_max",    64'(bus.Sum),    64'(688107));
    check("t6_result_max", 64'(bus.Result), 64'(1));
    check("t6_model_max",  64'(m_sum),      64'(688107));
    @(negedge clk);
    #2;
    set_coef_const(16'h8000);
    bus.Offset = 16'h8000;
    pulse_and_measure(lat, 1'b0);
    check("t6_sum_min",    64'(bus.Sum),    64'(21'h158000));
    check("t6_result_min", 64'(bus.Result), 64'(0));

    repeat (3) @(negedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

endmodule : tb_neuron_eval_sequencer
